freq_gate_counter: RTL and testbench

Gated edge counter for the frequency-counter datapath. It consumes the 1 Hz gate produced by the frequency divider and counts rising edges of the measured input `sig_in` while the gate is high. On each gate falling edge it latches the count, which is the measured frequency in Hz, and pulses a one-cycle valid strobe for the display/readout stage downstream.

---
 rtl/freq_gate_counter_if.sv | 22 ++
 rtl/freq_gate_counter.sv | 120 ++++++++++++
 tb/tb_freq_gate_counter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/freq_gate_counter_if.sv
// Bus between the frequency-counter gate stage and its consumers: gate and
// measured signal in, latched result with strobe, overflow and busy flags out.
interface freq_gate_counter_if #(
  parameter int CNT_W = 26
);
  logic             gate;
  logic             sig_in;
  logic [CNT_W-1:0] freq_out;
  logic             freq_valid;
  logic             ovf;
  logic             busy;

  modport master (
    output gate, sig_in,
    input  freq_out, freq_valid, ovf, busy
  );

  modport slave (
    input  gate, sig_in,
    output freq_out, freq_valid, ovf, busy
  );
endinterface

// File: rtl/freq_gate_counter.sv
// Gated edge counter: counts sig_in rising edges while the 1 Hz gate is high.
// Define FREQCNT_SYNC_EN for a 2-flop synchronizer on sig_in (board build).
module freq_gate_counter #(
  parameter int CNT_W = 26
) (
  input logic                clk,
  input logic                rst_n,
  freq_gate_counter_if.slave fc
);

  typedef enum logic [1:0] {IDLE, ARMED, COUNT, LATCH} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] freqOut_q, freqOut_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             edge_q;
  logic             synced;
  logic             sigRise;

`ifdef FREQCNT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], fc.sig_in};
  end

  assign synced = sync_q[1];
`else
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 1'b0;
    else        sync_q <= fc.sig_in;
  end

  assign synced = sync_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_q <= 1'b0;
    else        edge_q <= synced;
  end

  assign sigRise = synced & ~edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      freqOut_q <= '0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      freqOut_q <= freqOut_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // IDLE waits for a low gate so a window already open at reset release is skipped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    freqOut_d = freqOut_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fc.gate) state_d = ARMED;
      end
      ARMED: begin
        if (fc.gate) begin
          state_d = COUNT;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      COUNT: begin
        if (fc.gate) begin
          if (sigRise) begin
            if (cnt_q == CntMax) sat_d = 1'b1;
            else                 cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d   = LATCH;
          freqOut_d = cnt_q;
          ovf_d     = sat_q;
          valid_d   = 1'b1;
        end
      end
      LATCH: begin
        state_d = ARMED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == COUNT);
  end

  assign fc.freq_out   = freqOut_q;
  assign fc.freq_valid = valid_q;
  assign fc.ovf        = ovf_q;
  assign fc.busy       = busy_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter: a 26-bit and a 4-bit instance share
// the same gate/sig_in stimulus; windows come from a vector table.
module tb_freq_gate_counter;

`ifdef FREQCNT_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  typedef struct {
    int lowCyc;
    int highCyc;
    int period;
    bit boundary;
    int expFreqA;
    int expOvfA;
    int expFreqB;
    int expOvfB;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic gate  = 1'b0;
  logic sigIn = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulsesA, pulsesB;
  int capFreqA, capFreqB, capOvfA, capOvfB;
  int busyMidA, busyMidB;
  vec_t vecs[5];

  always #5 clk = ~clk;

  freq_gate_counter_if #(.CNT_W(26)) busA ();
  freq_gate_counter_if #(.CNT_W(4))  busB ();

  assign busA.gate   = gate;
  assign busA.sig_in = sigIn;
  assign busB.gate   = gate;
  assign busB.sig_in = sigIn;

  freq_gate_counter #(.CNT_W(26)) dutA (.clk(clk), .rst_n(rst_n), .fc(busA));
  freq_gate_counter #(.CNT_W(4))  dutB (.clk(clk), .rst_n(rst_n), .fc(busB));

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs, wait past the edge, record any valid strobe.
  task automatic applyStimulus(input logic g, input logic s);
    gate  = g;
    sigIn = s;
    @(posedge clk);
    #1;
    if (busA.freq_valid) begin
      pulsesA++;
      capFreqA = int'(busA.freq_out);
      capOvfA  = int'(busA.ovf);
    end
    if (busB.freq_valid) begin
      pulsesB++;
      capFreqB = int'(busB.freq_out);
      capOvfB  = int'(busB.ovf);
    end
  endtask

  function automatic logic sigPattern(input int j, input int period, input bit boundary,
                                      input int highCyc);
    if (boundary)
      return (j < 80) ? ((j % 20) >= 10) : (j >= highCyc - Lat);
    if (period == 0)
      return 1'b0;
    return ((j + period / 2) % period) < (period / 2);
  endfunction

  task automatic clearCapture();
    pulsesA  = 0;
    pulsesB  = 0;
    capFreqA = -1;
    capFreqB = -1;
    capOvfA  = -1;
    capOvfB  = -1;
  endtask

  task automatic runWindow(input int lowCyc, input int highCyc, input int period,
                           input bit boundary);
    clearCapture();
    for (int i = 0; i < lowCyc; i++) applyStimulus(1'b0, 1'b0);
    for (int j = 0; j < highCyc; j++) begin
      applyStimulus(1'b1, sigPattern(j, period, boundary, highCyc));
      if (j == highCyc / 2) begin
        busyMidA = int'(busA.busy);
        busyMidB = int'(busB.busy);
      end
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_freqA"},  int'(busA.freq_out),   0);
    checkOutput({tag, "_validA"}, int'(busA.freq_valid), 0);
    checkOutput({tag, "_ovfA"},   int'(busA.ovf),        0);
    checkOutput({tag, "_busyA"},  int'(busA.busy),       0);
    checkOutput({tag, "_freqB"},  int'(busB.freq_out),   0);
    checkOutput({tag, "_ovfB"},   int'(busB.ovf),        0);
    checkOutput({tag, "_busyB"},  int'(busB.busy),       0);
  endtask

  initial begin
    //            low  high  per  bnd  freqA ovfA freqB ovfB
    vecs[0] = '{10, 1000, 10,  1'b0, 100,  0,   15,   1};
    vecs[1] = '{10,  500,  0,  1'b0,   0,  0,    0,   0};
    vecs[2] = '{10,  200,  4,  1'b0,  50,  0,   15,   1};
    vecs[3] = '{10,  200, 40,  1'b0,   5,  0,    5,   0};
    vecs[4] = '{10,  100, 20,  1'b1,   4,  0,    4,   0};

    gate = 1'b1;
    #12;
    checkResetOutputs("reset");

    // Window already open when reset releases must produce no result.
    clearCapture();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 300; j++) applyStimulus(1'b1, sigPattern(j, 10, 1'b0, 300));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("startup_pulsesA", pulsesA, 0);
    checkOutput("startup_pulsesB", pulsesB, 0);

    for (int v = 0; v < 5; v++) begin
      runWindow(vecs[v].lowCyc, vecs[v].highCyc, vecs[v].period, vecs[v].boundary);
      $display("[TB] vector %0d: freqA=%0d freqB=%0d", v, capFreqA, capFreqB);
      checkOutput($sformatf("v%0d_pulsesA", v), pulsesA, 1);
      checkOutput($sformatf("v%0d_pulsesB", v), pulsesB, 1);
      checkOutput($sformatf("v%0d_freqA", v), capFreqA, vecs[v].expFreqA);
      checkOutput($sformatf("v%0d_ovfA", v), capOvfA, vecs[v].expOvfA);
      checkOutput($sformatf("v%0d_freqB", v), capFreqB, vecs[v].expFreqB);
      checkOutput($sformatf("v%0d_ovfB", v), capOvfB, vecs[v].expOvfB);
      checkOutput($sformatf("v%0d_busyMidA", v), busyMidA, 1);
      checkOutput($sformatf("v%0d_busyEndA", v), int'(busA.busy), 0);
      checkOutput($sformatf("v%0d_holdFreqA", v), int'(busA.freq_out), vecs[v].expFreqA);
    end

    // Reset halfway through a window clears outputs without a clock edge.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
    for (int j = 0; j < 250; j++) applyStimulus(1'b1, sigPattern(j, 10, 1'b0, 500));
    rst_n = 1'b0;
    #2;
    checkResetOutputs("midreset");
    clearCapture();
    for (int j = 250; j < 253; j++) applyStimulus(1'b1, sigPattern(j, 10, 1'b0, 500));
    rst_n = 1'b1;
    for (int j = 253; j < 500; j++) applyStimulus(1'b1, sigPattern(j, 10, 1'b0, 500));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("midreset_pulsesA", pulsesA, 0);
    checkOutput("midreset_pulsesB", pulsesB, 0);

    runWindow(10, 300, 10, 1'b0);
    checkOutput("after_reset_pulsesA", pulsesA, 1);
    checkOutput("after_reset_freqA", capFreqA, 30);
    checkOutput("after_reset_ovfA", capOvfA, 0);
    checkOutput("after_reset_freqB", capFreqB, 15);
    checkOutput("after_reset_ovfB", capOvfB, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
